controle_busca: RTL and testbench

Instruction-fetch controller that sequences the word-addressed instruction ROM.
- Owns the program counter and drives the ROM address.
- Captures each returned instruction into a 2-entry queue and hands it to decode over a valid/ready handshake.
- Accepts redirects (branch/jump) from execute.
- Stops with a fault flag when the PC leaves the populated ROM range.

---
 rtl/busca_pkg.sv | 22 ++
 rtl/controle_busca_if.sv | 41 ++++
 rtl/fila_busca.sv | 83 ++++++++
 rtl/controle_busca.sv | 132 +++++++++++++
 tb/tb_controle_busca.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/busca_pkg.sv
// busca_pkg: shared types and widths for the instruction-fetch controller.
//   estado_t  : fetch FSM state encoding (IDLE, RUN, FAULT)
//   entrada_t : queue entry {pc, instrucao}
//   PC_W      : program-counter / ROM address width
//   INSTR_W   : instruction width
package busca_pkg;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } estado_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instrucao;
    } entrada_t;

endpackage

// File: rtl/controle_busca_if.sv
// controle_busca_if: groups the ROM port, the decode-side valid/ready
// handshake and the redirect request of the fetch controller.
//   mem_pc/mem_instrucao          : combinational ROM read port
//   out_valid/out_ready/out_*     : queue head handed to decode
//   redirect_valid/redirect_pc    : branch/jump request from execute
// Modports: master = fetch controller, slave = ROM/decode/execute side.
interface controle_busca_if;
    import busca_pkg::*;

    logic [PC_W-1:0]    mem_pc;
    logic [INSTR_W-1:0] mem_instrucao;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instrucao;
    logic [PC_W-1:0]    out_pc;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;

    modport master (
        output mem_pc,
        input  mem_instrucao,
        output out_valid,
        input  out_ready,
        output out_instrucao,
        output out_pc,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  mem_pc,
        output mem_instrucao,
        input  out_valid,
        output out_ready,
        input  out_instrucao,
        input  out_pc,
        output redirect_valid,
        output redirect_pc
    );

endinterface

// File: rtl/fila_busca.sv
// fila_busca: 2-entry FIFO of fetched instructions.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write din at the tail
//   pop        : drop the head (caller guarantees count != 0)
//   flush      : discard all entries, overrides push
//   din        : entry to write
//   dout       : head entry (registered)
//   count      : number of valid entries (0..2)
// Entry 0 is always the head, so dout comes straight from a register.
module fila_busca
    import busca_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  entrada_t   din,
    output entrada_t   dout,
    output logic [1:0] count
);

    entrada_t   ent0_q, ent0_d;
    entrada_t   ent1_q, ent1_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        ent0_d  = din;
                        count_d = 2'd1;
                    end else if (count_q == 2'd1) begin
                        ent1_d  = din;
                        count_d = 2'd2;
                    end
                end
                2'b01: begin
                    if (count_q != 2'd0) begin
                        ent0_d  = ent1_q;
                        count_d = count_q - 2'd1;
                    end
                end
                2'b11: begin
                    // Count is unchanged; with two entries the tail shifts up.
                    if (count_q == 2'd2) begin
                        ent0_d = ent1_q;
                        ent1_d = din;
                    end else if (count_q == 2'd1) begin
                        ent0_d = din;
                    end else begin
                        ent0_d  = din;
                        count_d = 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q  <= '0;
            ent1_q  <= '0;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    assign dout  = ent0_q;
    assign count = count_q;

endmodule

// File: rtl/controle_busca.sv
// controle_busca: instruction-fetch controller for a word-addressed ROM.
// Owns the PC, reads the combinational ROM, queues instructions in
// fila_busca and presents them to decode; accepts redirects; stops with
// fault when the PC leaves 0..MEM_WORDS-1.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : leave IDLE and begin fetching
//   bus (master)  : ROM port, decode handshake, redirect request
//   fault         : state is FAULT
//   busy          : state is RUN
//   perf_fetched  : saturating push count   (CONTROLE_BUSCA_PERF_EN only)
//   perf_stall    : saturating full-stall count (CONTROLE_BUSCA_PERF_EN only)
// Build option: CONTROLE_BUSCA_PERF_EN adds the two performance counters.
//
// state    | meaning
// ST_IDLE  | no fetch, waiting for start
// ST_RUN   | fetching whenever the queue can take an entry
// ST_FAULT | PC out of range, no fetch until an in-range redirect
module controle_busca
    import busca_pkg::*;
#(
    parameter int              MEM_WORDS = 64,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    controle_busca_if.master        bus,
    output logic                    fault,
    output logic                    busy
`ifdef CONTROLE_BUSCA_PERF_EN
    ,
    output logic [31:0]             perf_fetched,
    output logic [31:0]             perf_stall
`endif
);

    localparam logic [PC_W-1:0] MEM_LIMIT = PC_W'(MEM_WORDS);

    estado_t         state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;

    logic            push, pop, flush, redir, room, pc_ok;
    logic [1:0]      count;
    entrada_t        din, dout;

    assign bus.mem_pc    = pc_q;
    assign bus.out_valid = (count != 2'd0);
    assign pop           = bus.out_valid && bus.out_ready;
    assign redir         = bus.redirect_valid && (state_q != ST_IDLE);
    assign pc_ok         = (pc_q < MEM_LIMIT);
    // A full queue still takes a new entry when the head leaves this cycle.
    assign room          = (count != 2'd2) || pop;
    assign din           = '{pc: pc_q, instrucao: bus.mem_instrucao};

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!redir && room) begin
                    if (pc_ok) begin
                        push = 1'b1;
                        pc_d = pc_q + PC_W'(1);
                    end else begin
                        state_d = ST_FAULT;
                    end
                end
            end
            ST_FAULT: ;
            default: state_d = ST_IDLE;
        endcase
        // Redirect wins over everything; an out-of-range target parks in FAULT.
        if (redir) begin
            flush   = 1'b1;
            pc_d    = bus.redirect_pc;
            state_d = (bus.redirect_pc < MEM_LIMIT) ? ST_RUN : ST_FAULT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fila_busca u_fila (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (din),
        .dout  (dout),
        .count (count)
    );

    assign bus.out_instrucao = dout.instrucao;
    assign bus.out_pc        = dout.pc;
    assign fault             = (state_q == ST_FAULT);
    assign busy              = (state_q == ST_RUN);

`ifdef CONTROLE_BUSCA_PERF_EN
    logic [31:0] perf_fetched_q, perf_stall_q;
    logic        stall;

    assign stall = (state_q == ST_RUN) && (count == 2'd2) && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (push && (perf_fetched_q != '1)) perf_fetched_q <= perf_fetched_q + 32'd1;
            if (stall && (perf_stall_q != '1))  perf_stall_q   <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_controle_busca.sv
// tb_controle_busca: directed self-checking bench for controle_busca.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_controle_busca;
    import busca_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic fault, busy;
`ifdef CONTROLE_BUSCA_PERF_EN
    logic [31:0] perf_fetched, perf_stall;
`endif

    int n_chk = 0;
    int n_err = 0;

    controle_busca_if bus ();

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [63:0] a);
        case (a)
            64'd0:   rom = 32'h0000_0000;
            64'd1:   rom = 32'h0070_2083;
            64'd2:   rom = 32'h0153_8FB3;
            64'd5:   rom = 32'h03DE_2423;
            default: rom = {16'hA5A5, a[15:0]};
        endcase
    endfunction

    always_comb bus.mem_instrucao = rom(bus.mem_pc);

    controle_busca #(.MEM_WORDS(64), .RESET_PC(64'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus.master),
        .fault (fault),
        .busy  (busy)
`ifdef CONTROLE_BUSCA_PERF_EN
        ,
        .perf_fetched (perf_fetched),
        .perf_stall   (perf_stall)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n              = 1'b0;
        start              = 1'b0;
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        repeat (2) @(negedge clk);

        // reset values
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_pc", bus.out_pc, 0);
        chk("rst_instr", bus.out_instrucao, 0);
        chk("rst_fault", fault, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_pc", bus.mem_pc, 0);
`ifdef CONTROLE_BUSCA_PERF_EN
        chk("rst_perf_f", perf_fetched, 0);
        chk("rst_perf_s", perf_stall, 0);
`endif
        rst_n = 1'b1;

        // streaming with out_ready held high
        bus.out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_valid", bus.out_valid, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("stream_valid", bus.out_valid, 1);
            chk("stream_pc", bus.out_pc, 64'(i));
            chk("stream_instr", bus.out_instrucao, 64'(rom(64'(i))));
        end
        chk("stream_mem_pc", bus.mem_pc, 8);

        // back-pressure: queue fills with PC 0,1 and the PC holds at 2
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("stall_valid", bus.out_valid, 1);
        chk("stall_head", bus.out_pc, 0);
        chk("stall_mem_pc", bus.mem_pc, 2);
`ifdef CONTROLE_BUSCA_PERF_EN
        chk("stall_perf_s", perf_stall, 3);
        chk("stall_perf_f", perf_fetched, 2);
`endif
        bus.out_ready = 1'b1;
        step();
        chk("release_pc1", bus.out_pc, 1);
        step();
        chk("release_pc2", bus.out_pc, 2);
        chk("release_instr2", bus.out_instrucao, 64'h0153_8FB3);
        chk("release_mem_pc", bus.mem_pc, 4);

        // redirect to 5 while the queue holds PC 2,3
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'd5;
        step();
        bus.redirect_valid = 1'b0;
        chk("redir_bubble", bus.out_valid, 0);
        chk("redir_mem_pc", bus.mem_pc, 5);
        step();
        chk("redir_valid", bus.out_valid, 1);
        chk("redir_pc5", bus.out_pc, 5);
        chk("redir_instr5", bus.out_instrucao, 64'h03DE_2423);
        bus.out_ready = 1'b1;
        step();
        chk("redir_pc6", bus.out_pc, 6);

        // run off the end of the ROM
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'd60;
        step();
        bus.redirect_valid = 1'b0;
        chk("end_bubble", bus.out_valid, 0);
        for (int i = 60; i < 64; i++) begin
            step();
            chk("end_pc", bus.out_pc, 64'(i));
        end
        step();
        chk("end_fault", fault, 1);
        chk("end_busy", busy, 0);
        chk("end_valid", bus.out_valid, 0);
        step();
        chk("end_valid_hold", bus.out_valid, 0);
        chk("end_mem_pc", bus.mem_pc, 64);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'd1;
        step();
        bus.redirect_valid = 1'b0;
        chk("recov_fault", fault, 0);
        chk("recov_busy", busy, 1);
        step();
        chk("recov_pc1", bus.out_pc, 1);
        chk("recov_instr1", bus.out_instrucao, 64'h0070_2083);

        // out-of-range redirect from RUN
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'd100;
        step();
        bus.redirect_valid = 1'b0;
        chk("oor_mem_pc", bus.mem_pc, 100);
        step();
        chk("oor_fault", fault, 1);
        chk("oor_busy", busy, 0);
        chk("oor_valid", bus.out_valid, 0);
        step();
        chk("oor_pc_hold", bus.mem_pc, 100);

        // asynchronous reset with a full queue
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'd3;
        step();
        bus.redirect_valid = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        chk("full_valid", bus.out_valid, 1);
        chk("full_head", bus.out_pc, 3);
        chk("full_mem_pc", bus.mem_pc, 5);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_mem_pc", bus.mem_pc, 0);
        chk("arst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("restart_pc", bus.out_pc, 64'(i));
            chk("restart_instr", bus.out_instrucao, 64'(rom(64'(i))));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
